// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: frame-sequencer states and parity modes.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and wraps, flagging the last and second-to-last cycles.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 417
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick,
    output logic almost_tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick        = (count == CNT_W'(CLKS_PER_BIT - 1));
    // Lets a consumer register a strobe that lands on the final cycle of the period.
    assign almost_tick = (count == CNT_W'(CLKS_PER_BIT - 2));

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a FIFO read port and sends each as an async UART frame (start, LSB-first data, parity, stop).
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | line high; waiting for enable && !fifo_empty
// ST_START  | start bit (tx=0) for one bit period
// ST_DATA   | DATA_WIDTH data bits, LSB first
// ST_PARITY | parity bit of the latched word (only when PARITY != 0)
// ST_STOP   | STOP_BITS stop bits; frame_done in the final cycle
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 417,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_cpb
            $error("fifo_uart_tx: CLKS_PER_BIT must be at least 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("fifo_uart_tx: PARITY must be 0, 1 or 2");
        end
        if (DATA_WIDTH < 1) begin : g_bad_width
            $error("fifo_uart_tx: DATA_WIDTH must be at least 1");
        end
    endgenerate

    localparam int                BIT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
    localparam logic              STOP_LAST = (STOP_BITS == 2);

    uart_state_t           state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_next;
    logic                  par_bit;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  stop_cnt;
    logic                  stop_last;
    logic                  tick;
    logic                  almost_tick;
    logic                  baud_clear;

    assign baud_clear = (state == ST_IDLE);
    assign shreg_next = shreg >> 1;
    assign stop_last  = (stop_cnt == STOP_LAST);

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk         (clk),
        .rst         (rst),
        .clear       (baud_clear),
        .tick        (tick),
        .almost_tick (almost_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            par_bit    <= 1'b0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            fifo_rd_en <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            fifo_rd_en <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable && !fifo_empty) begin
                        // Parity is fixed at latch time so later FIFO head changes cannot affect it.
                        shreg      <= fifo_data;
                        par_bit    <= (^fifo_data) ^ (PARITY == PAR_ODD);
                        fifo_rd_en <= 1'b1;
                        tx         <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        tx    <= shreg[0];
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (PARITY != PAR_NONE) begin
                                tx    <= par_bit;
                                state <= ST_PARITY;
                            end else begin
                                tx       <= 1'b1;
                                stop_cnt <= 1'b0;
                                state    <= ST_STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= shreg_next;
                            tx      <= shreg_next[0];
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (almost_tick && stop_last) begin
                        frame_done <= 1'b1;
                    end
                    if (tick) begin
                        if (stop_last) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: four configurations fed from FIFO models, checked cycle by cycle against a frame model.
module tb_fifo_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] en;
    logic [3:0] tx_w, busy_w, rd_w, done_w;

    logic [7:0] mem [4][16];
    logic [3:0] wp  [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
    logic [3:0] rp  [4] = '{4'd0, 4'd0, 4'd0, 4'd0};

    int n_checks = 0;
    int n_fail   = 0;
    int pop_empty_errs = 0;

    // Each entry: {tx, busy, fifo_rd_en, frame_done} for one cycle.
    logic [3:0] exp_q [$];
    logic [3:0] obs_q [$];

    always #5 clk = ~clk;

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst), .enable(en[0]), .fifo_data(mem[0][rp[0]]), .fifo_empty(rp[0] == wp[0]),
        .fifo_rd_en(rd_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(done_w[0]));
    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .enable(en[1]), .fifo_data(mem[1][rp[1]]), .fifo_empty(rp[1] == wp[1]),
        .fifo_rd_en(rd_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(done_w[1]));
    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rst(rst), .enable(en[2]), .fifo_data(mem[2][rp[2]]), .fifo_empty(rp[2] == wp[2]),
        .fifo_rd_en(rd_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(done_w[2]));
    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(3), .PARITY(0), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .rst(rst), .enable(en[3]), .fifo_data(mem[3][rp[3]]), .fifo_empty(rp[3] == wp[3]),
        .fifo_rd_en(rd_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .frame_done(done_w[3]));

    // FIFO read side: head advances one cycle after a pop.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rd_w[i]) begin
                if (rp[i] == wp[i]) pop_empty_errs++;
                else rp[i] <= rp[i] + 4'd1;
            end
        end
    end

    function automatic int cfg_cpb(int i);
        return (i == 3) ? 3 : 4;
    endfunction

    function automatic int cfg_par(int i);
        return (i == 1) ? 1 : ((i == 2) ? 2 : 0);
    endfunction

    function automatic int cfg_stop(int i);
        return (i == 3) ? 2 : 1;
    endfunction

    function automatic int frame_len(int i);
        return cfg_cpb(i) * (1 + 8 + ((cfg_par(i) != 0) ? 1 : 0) + cfg_stop(i));
    endfunction

    // Expected frame as a list of line levels, each stretched over CLKS_PER_BIT cycles.
    function automatic void model_frame(int idx, logic [7:0] b, int trunc);
        logic bits [$];
        int   cpb;
        int   len;
        cpb = cfg_cpb(idx);
        bits.push_back(1'b0);
        for (int k = 0; k < 8; k++) bits.push_back(b[k]);
        if (cfg_par(idx) == 1) bits.push_back(^b);
        if (cfg_par(idx) == 2) bits.push_back(~(^b));
        for (int s = 0; s < cfg_stop(idx); s++) bits.push_back(1'b1);
        len = bits.size() * cpb;
        for (int k = 0; k < len; k++) begin
            if (trunc == 0 || k < trunc)
                exp_q.push_back({bits[k / cpb], 1'b1, 1'(k == 0), 1'(k == len - 1)});
        end
    endfunction

    function automatic void model_gap();
        exp_q.push_back(4'b1000);
    endfunction

    task automatic push_byte(int idx, logic [7:0] b);
        mem[idx][wp[idx]] = b;
        wp[idx] = wp[idx] + 4'd1;
    endtask

    task automatic clear_queues();
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic capture(int idx, int ncyc, int drop_at, int rst_at);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            obs_q.push_back({tx_w[idx], busy_w[idx], rd_w[idx], done_w[idx]});
            if (c == drop_at) en[idx] = 1'b0;
            if (c == rst_at) rst = 1'b1;
            else if (rst_at > 0 && c == rst_at + 1) rst = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 4'b1111;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({tx_w[i], busy_w[i], rd_w[i], done_w[i]} !== 4'b1000) begin
                n_fail++;
                $display("FAIL reset dut%0d: observed tx/busy/rd/done=%b required 1000", i,
                         {tx_w[i], busy_w[i], rd_w[i], done_w[i]});
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] b;
        for (int r = 0; r < 4; r++) begin
            b = (r == 0) ? 8'hA5 : 8'($urandom_range(255));
            clear_queues();
            push_byte(0, b);
            model_frame(0, b, 0);
            capture(0, exp_q.size() + 8, 0, 0);
            for (int k = 0; k < obs_q.size(); k++) begin
                n_checks++;
                if (obs_q[k] !== ((k < exp_q.size()) ? exp_q[k] : 4'b1000)) begin
                    n_fail++;
                    $display("FAIL basic byte %h cyc %0d: observed %b required %b", b, k, obs_q[k],
                             (k < exp_q.size()) ? exp_q[k] : 4'b1000);
                end
            end
        end
    endtask

    task automatic test_parity();
        logic [7:0] b;
        int         idx;
        for (int r = 0; r < 7; r++) begin
            idx = (r == 2 || r == 5) ? 2 : 1;
            b   = (r == 0 || r == 2) ? 8'hA5 : ((r == 1) ? 8'h07 : 8'($urandom_range(255)));
            clear_queues();
            push_byte(idx, b);
            model_frame(idx, b, 0);
            n_checks++;
            if (exp_q.size() != 44) begin
                n_fail++;
                $display("FAIL parity_len dut%0d: model %0d required 44", idx, exp_q.size());
            end
            capture(idx, exp_q.size() + 6, 0, 0);
            for (int k = 0; k < obs_q.size(); k++) begin
                n_checks++;
                if (obs_q[k] !== ((k < exp_q.size()) ? exp_q[k] : 4'b1000)) begin
                    n_fail++;
                    $display("FAIL parity dut%0d byte %h cyc %0d: observed %b required %b", idx, b, k,
                             obs_q[k], (k < exp_q.size()) ? exp_q[k] : 4'b1000);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bs [$];
        for (int r = 0; r < 3; r++) begin
            bs.delete();
            if (r == 0) begin
                bs.push_back(8'h00); bs.push_back(8'hFF); bs.push_back(8'h3C);
            end else begin
                for (int j = 0; j < 2 + r; j++) bs.push_back(8'($urandom_range(255)));
            end
            clear_queues();
            for (int j = 0; j < bs.size(); j++) begin
                push_byte(0, bs[j]);
                if (j > 0) model_gap();
                model_frame(0, bs[j], 0);
            end
            capture(0, exp_q.size() + 20, 0, 0);
            for (int k = 0; k < obs_q.size(); k++) begin
                n_checks++;
                if (obs_q[k] !== ((k < exp_q.size()) ? exp_q[k] : 4'b1000)) begin
                    n_fail++;
                    $display("FAIL back_to_back run %0d cyc %0d: observed %b required %b", r, k, obs_q[k],
                             (k < exp_q.size()) ? exp_q[k] : 4'b1000);
                end
            end
        end
    endtask

    task automatic test_stop2();
        logic [7:0] b;
        for (int r = 0; r < 3; r++) begin
            b = (r == 0) ? 8'h81 : 8'($urandom_range(255));
            clear_queues();
            push_byte(3, b);
            if (r == 2) begin
                push_byte(3, ~b);
                model_frame(3, b, 0);
                model_gap();
                model_frame(3, ~b, 0);
            end else begin
                model_frame(3, b, 0);
            end
            capture(3, exp_q.size() + 6, 0, 0);
            for (int k = 0; k < obs_q.size(); k++) begin
                n_checks++;
                if (obs_q[k] !== ((k < exp_q.size()) ? exp_q[k] : 4'b1000)) begin
                    n_fail++;
                    $display("FAIL stop2 byte %h cyc %0d: observed %b required %b", b, k, obs_q[k],
                             (k < exp_q.size()) ? exp_q[k] : 4'b1000);
                end
            end
        end
    endtask

    task automatic test_flow_control();
        logic [7:0] b1, b2;
        b1 = 8'($urandom_range(255));
        b2 = 8'($urandom_range(255));

        // Held off by enable: line idle and no pop while the FIFO is non-empty.
        clear_queues();
        en[0] = 1'b0;
        push_byte(0, b1);
        capture(0, 60, 0, 0);
        en[0] = 1'b1;
        model_frame(0, b1, 0);
        for (int k = 0; k < 60; k++) exp_q.push_front(4'b1000);
        capture(0, frame_len(0) + 6, 0, 0);

        // Enable dropped mid-frame: frame completes, the next byte stays queued.
        push_byte(0, b1 ^ 8'h5A);
        push_byte(0, b2);
        for (int k = 0; k < 6; k++) model_gap();
        model_frame(0, b1 ^ 8'h5A, 0);
        for (int k = 0; k < 80; k++) model_gap();
        capture(0, frame_len(0) + 80, 10, 0);
        en[0] = 1'b1;
        model_frame(0, b2, 0);
        for (int k = 0; k < 150; k++) model_gap();
        capture(0, frame_len(0) + 150, 0, 0);

        for (int k = 0; k < obs_q.size(); k++) begin
            n_checks++;
            if (obs_q[k] !== ((k < exp_q.size()) ? exp_q[k] : 4'b1000)) begin
                n_fail++;
                $display("FAIL flow_control cyc %0d: observed %b required %b", k, obs_q[k],
                         (k < exp_q.size()) ? exp_q[k] : 4'b1000);
            end
        end
        n_checks++;
        if (exp_q.size() != obs_q.size()) begin
            n_fail++;
            $display("FAIL flow_control_len: observed %0d cycles required %0d", obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b1, b2;
        b1 = 8'($urandom_range(255));
        b2 = ~b1;
        clear_queues();
        push_byte(0, b1);
        push_byte(0, b2);
        // Cycle 14 of the frame falls inside the third data bit (cycles 13..16).
        model_frame(0, b1, 14);
        model_gap();
        model_frame(0, b2, 0);
        capture(0, exp_q.size() + 30, 0, 14);
        for (int k = 0; k < obs_q.size(); k++) begin
            n_checks++;
            if (obs_q[k] !== ((k < exp_q.size()) ? exp_q[k] : 4'b1000)) begin
                n_fail++;
                $display("FAIL reset_mid_frame cyc %0d: observed %b required %b", k, obs_q[k],
                         (k < exp_q.size()) ? exp_q[k] : 4'b1000);
            end
        end
        n_checks++;
        if (rp[0] !== wp[0]) begin
            n_fail++;
            $display("FAIL reset_mid_frame_fifo: observed rp=%0d required wp=%0d", rp[0], wp[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_stop2();
        test_flow_control();
        test_reset_mid_frame();
        n_checks++;
        if (pop_empty_errs !== 0) begin
            n_fail++;
            $display("FAIL pop_while_empty: observed %0d pops required 0", pop_empty_errs);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Consumer side of the byte FIFO. Pops bytes from a FIFO read port and serialises each one as an asynchronous UART frame on a single line: start bit, data LSB-first, optional parity, then 1 or 2 stop bits. Sits between the FIFO output and the board TX pin for debug/bridge traffic. Paces itself entirely from the FIFO `empty` flag and an `enable` input.

Parameters:
- DATA_WIDTH, 8, bits per frame; also the FIFO data width.
- CLKS_PER_BIT, 417, clk cycles per bit (48 MHz / 115200). Legal range is ≥ 2.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits: 1 or 2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- enable  input  1  permits new frames to start; sampled only in IDLE
- fifo_data  input  DATA_WIDTH  FIFO head word; valid whenever fifo_empty=0
- fifo_empty  input  1  FIFO empty flag
- fifo_rd_en  output  1  one-cycle pop strobe to the FIFO
- tx  output  1  serial line; idles high
- busy  output  1  high from the start of the start bit to the end of the last stop bit
- frame_done  output  1  one-cycle pulse in the final cycle of the last stop bit

Behaviour:
- Reset is synchronous, active-high; clock is clk. All outputs are registered.
- Reset values: tx=1, fifo_rd_en=0, busy=0, frame_done=0, state=IDLE, all counters 0.
- States and transitions: IDLE → START → DATA → (PARITY if PARITY≠0) → STOP → IDLE.
- IDLE, cycle N, with enable=1 and fifo_empty=0:
  - latch fifo_data into the shift register;
  - assert fifo_rd_en for exactly cycle N+1;
  - go to START.
- START:
  - tx=0 and busy=1 from cycle N+1 for CLKS_PER_BIT cycles.
- DATA:
  - DATA_WIDTH bits, LSB first, each held CLKS_PER_BIT cycles;
  - shift right once per bit boundary.
- PARITY:
  - one bit period; even = XOR of the latched data, odd = its inverse;
  - parity is computed from the latched byte, never from fifo_data.
- STOP:
  - tx=1 for STOP_BITS×CLKS_PER_BIT cycles;
  - frame_done pulses in the final cycle;
  - busy drops at the next cycle (back in IDLE).
- Frame length is CLKS_PER_BIT×(1+DATA_WIDTH+(PARITY≠0)+STOP_BITS) cycles.
- Back-to-back frames:
  - at least one IDLE cycle (tx=1) separates consecutive frames;
  - a non-empty FIFO gives exactly a 1-cycle gap.
- Bit timer:
  - counts 0..CLKS_PER_BIT-1 and wraps;
  - bit boundary is the cycle where count == CLKS_PER_BIT-1;
  - width is $clog2(CLKS_PER_BIT).
- Bit counter: 0..DATA_WIDTH-1; wraps to 0 on leaving DATA.
- fifo_empty and enable are ignored outside IDLE.
- Deasserting enable mid-frame has no effect; the frame completes.
- Exactly one pop per frame; no pop while fifo_empty=1.
- The pop occurs only after the head has been latched. Head update latency after a pop is irrelevant because the next sample is ≥ one frame later.
- Reset mid-frame:
  - next cycle tx=1, busy=0, no pop, no frame_done;
  - the partial frame is abandoned.
- Illegal parameter values (CLKS_PER_BIT < 2, STOP_BITS ∉ {1,2}, PARITY > 2) are rejected at elaboration.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - parity constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2.
- Sub-module uart_baud_counter:
  - inputs clk, rst, clear;
  - output tick, high on the last cycle of each bit period;
  - parameter CLKS_PER_BIT.
  It is reused by a future RX block.

Test Plan:
- Basic frame, CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1, FIFO holds 0xA5, enable=1:
  - fifo_rd_en pulses once;
  - tx reads 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total);
  - frame_done pulses at cycle 40 of the frame; busy=1 for exactly 40 cycles.
- Parity:
  - PARITY=1, byte 0xA5 → parity bit 0;
  - PARITY=2, byte 0xA5 → parity bit 1;
  - PARITY=1, byte 0x07 → parity bit 1;
  - frame is 44 cycles at CLKS_PER_BIT=4.
- Back-to-back: 3 bytes 0x00, 0xFF, 0x3C queued →
  - three frames separated by exactly one tx=1 idle cycle;
  - three single-cycle pops;
  - no pop after fifo_empty rises.
- Flow control:
  - enable=0 with a non-empty FIFO → tx stays 1, no pop;
  - enable dropped mid-frame → current frame completes, no further frame starts;
  - fifo_empty=1 → module idles indefinitely.
- Reset mid-frame: assert rst during the 3rd data bit →
  - next cycle tx=1, busy=0, fifo_rd_en=0;
  - after release, the next queued byte transmits correctly;
  - the abandoned byte is not resent.
- STOP_BITS=2, CLKS_PER_BIT=3, byte 0x81 → stop high for 6 cycles; frame_done in the final cycle of the second stop bit.
